// File: rtl/byte_word_packer.sv
// byte_word_packer: packs BYTES_IN consecutive bytes from a valid/ready byte stream
// into one word (byte k in bits [8k+7:8k]) for the compute stage. A fill buffer plus a
// one-word output register let the next word fill while the previous one waits.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_data/in_valid      byte stream input
//   in_ready              combinational: byte can be taken this cycle
//   flush                 synchronous discard of the partially filled word
//   out_word/out_valid    registered packed word and its valid flag
//   out_ready             compute stage takes out_word this cycle
//   byte_idx              next fill slot to be written
//   word_count            delivered words, modulo 256
module byte_word_packer #(
    parameter int unsigned LOG2_BYTES_IN = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    output logic [(1 << LOG2_BYTES_IN)*8-1:0] out_word,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LOG2_BYTES_IN-1:0]          byte_idx,
    output logic [7:0]                        word_count
);

    localparam int unsigned BYTES_IN = 1 << LOG2_BYTES_IN;
    localparam int unsigned WORD_W   = BYTES_IN * 8;
    localparam int unsigned LAST_IDX = BYTES_IN - 1;

    typedef enum logic {
        FILLING  = 1'b0,
        WAIT_OUT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] fill_buf;
    logic [WORD_W-1:0] fill_merged;
    logic              accept;
    logic              out_free;
    logic              last_byte;
    logic              out_take;

    assign in_ready  = (state == FILLING) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_free  = ~out_valid | out_ready;
    assign out_take  = out_valid & out_ready;
    assign last_byte = (byte_idx == LOG2_BYTES_IN'(LAST_IDX));

    // Fill buffer with the incoming byte dropped into slot byte_idx.
    always_comb begin
        fill_merged = fill_buf;
        for (int unsigned k = 0; k < BYTES_IN; k++) begin
            if (byte_idx == LOG2_BYTES_IN'(k)) begin
                fill_merged[8*k +: 8] = in_data;
            end
        end
    end

    // Next-state logic; flush always returns to FILLING.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FILLING;
        end else begin
            case (state)
                FILLING: begin
                    if (accept && last_byte && !out_free) begin
                        state_nxt = WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (out_ready) begin
                        state_nxt = FILLING;
                    end
                end
                default: state_nxt = FILLING;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILLING;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill buffer, output register and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            fill_buf   <= '0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            if (out_take) begin
                out_valid  <= 1'b0;
                word_count <= word_count + 8'd1;
            end

            if (flush) begin
                byte_idx <= '0;
            end else if (accept) begin
                fill_buf <= fill_merged;
                byte_idx <= byte_idx + LOG2_BYTES_IN'(1);
                // Completed word goes straight out when the output slot frees up.
                if (last_byte && out_free) begin
                    out_word  <= fill_merged;
                    out_valid <= 1'b1;
                end
            end else if ((state == WAIT_OUT) && out_ready) begin
                // Parked word replaces the one being consumed this edge.
                out_word  <= fill_buf;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer (LOG2_BYTES_IN = 3, 64-bit words).
// A word-level model (queue of completed words + list of pending bytes) predicts every
// output each cycle; tables and hand sequences add fixed expected values.
module tb_byte_word_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  byte_idx;
    logic [7:0]  word_count;

    byte_word_packer #(.LOG2_BYTES_IN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .byte_idx   (byte_idx),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model state.
    logic [63:0] mq[$];
    logic [7:0]  part[$];
    int          m_cnt;
    int          m_delivered;

    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_word;
        logic [2:0]  e_idx;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_cnt = 0;
    endtask

    // Drive one cycle, compare all outputs with the model, advance model and clock.
    task automatic do_cycle(input logic iv, input logic [7:0] id, input logic fl,
                            input logic ordy, output logic ir);
        logic        m_valid;
        logic        m_ready;
        logic        acc;
        logic        hs;
        logic [63:0] w;
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        #1;
        m_valid = (mq.size() > 0);
        m_ready = !fl && (mq.size() < 2);
        ir = in_ready;
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) check("out_word", out_word, mq[0]);
        check("byte_idx", 64'(byte_idx), 64'(part.size()));
        check("word_count", 64'(word_count), 64'(m_cnt));
        acc = iv && m_ready;
        hs  = m_valid && ordy;
        // A complete word parked behind the output register is lost on flush.
        if (fl && mq.size() == 2) void'(mq.pop_back());
        if (hs) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % 256;
            m_delivered++;
        end
        if (fl) begin
            part.delete();
        end else if (acc) begin
            part.push_back(id);
            if (part.size() == 8) begin
                w = '0;
                for (int k = 0; k < 8; k++) w = w | (64'(part[k]) << (8 * k));
                mq.push_back(w);
                part.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic iv, input logic [7:0] id, input logic fl, input logic ordy,
                           input logic e_ir, input logic e_ov, input logic [63:0] e_word,
                           input logic [2:0] e_idx, input logic [7:0] e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_word = e_word; v.e_idx = e_idx; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Assert reset between edges and check the asynchronous clear before any clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_word"}, out_word, 64'd0);
        check({tag, "_byte_idx"}, 64'(byte_idx), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic ir;
        int   start;
        int   cyc;
        total = 0;
        bad = 0;
        m_delivered = 0;
        model_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word", out_word, 64'd0);
        check("rst_byte_idx", 64'(byte_idx), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: bytes 01..08 back-to-back, out_ready=1.
        for (int k = 0; k < 8; k++)
            add_vec(1'b1, 8'(k + 1), 1'b0, 1'b1, 1'b1, k == 7, 64'h0807060504030201, 3'(k + 1), 8'd0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 3'd0, 8'd1);
        // Test 3: partial word, flush with a byte presented, then a clean word.
        add_vec(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 3'd1, 8'd1);
        add_vec(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 3'd2, 8'd1);
        add_vec(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 3'd3, 8'd1);
        add_vec(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 3'd0, 8'd1);
        for (int k = 0; k < 8; k++)
            add_vec(1'b1, 8'(8'h21 + k), 1'b0, 1'b1, 1'b1, k == 7, 64'h2827262524232221, 3'(k + 1), 8'd1);
        add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 3'd0, 8'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            do_cycle(vecs[i].iv, vecs[i].id, vecs[i].fl, vecs[i].ordy, ir);
            check("vec_in_ready", 64'(ir), 64'(vecs[i].e_ir));
            check("vec_out_valid", 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) check("vec_out_word", out_word, vecs[i].e_word);
            check("vec_byte_idx", 64'(byte_idx), 64'(vecs[i].e_idx));
            check("vec_word_count", 64'(word_count), 64'(vecs[i].e_cnt));
        end

        // Test 2: output stalled, 16 bytes fill output register and buffer.
        for (int k = 0; k < 16; k++) do_cycle(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, ir);
        check("t2_held_valid", 64'(out_valid), 64'd1);
        check("t2_held_word", out_word, 64'h1716151413121110);
        do_cycle(1'b1, 8'h99, 1'b0, 1'b0, ir);
        check("t2_wait_in_ready", 64'(ir), 64'd0);
        check("t2_still_word", out_word, 64'h1716151413121110);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, ir);
        check("t2_release_in_ready", 64'(ir), 64'd0);
        check("t2_second_valid", 64'(out_valid), 64'd1);
        check("t2_second_word", out_word, 64'h1F1E1D1C1B1A1918);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, ir);
        check("t2_refill_in_ready", 64'(ir), 64'd1);
        check("t2_drained", 64'(out_valid), 64'd0);
        check("t2_count", 64'(word_count), 64'd4);

        // Test 4: 256 words wrap the counter, 257th gives 1.
        async_reset("t4");
        for (int k = 0; k < 256 * 8; k++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b1, ir);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, ir);
        check("t4_wrap", 64'(word_count), 64'd0);
        for (int k = 0; k < 8; k++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b1, ir);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, ir);
        check("t4_after_wrap", 64'(word_count), 64'd1);

        // Test 5: reset mid-word and while a word is parked.
        for (int k = 0; k < 5; k++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, ir);
        check("t5_mid_idx", 64'(byte_idx), 64'd5);
        async_reset("t5a");
        for (int k = 0; k < 16; k++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, ir);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, ir);
        check("t5_parked_in_ready", 64'(ir), 64'd0);
        async_reset("t5b");
        for (int k = 0; k < 8; k++) do_cycle(1'b1, 8'(8'h31 + k), 1'b0, 1'b0, ir);
        check("t5_clean_valid", 64'(out_valid), 64'd1);
        check("t5_clean_word", out_word, 64'h3837363534333231);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, ir);

        // Test 6: random handshakes and occasional flush against the model.
        start = m_delivered;
        cyc = 0;
        while ((m_delivered - start) < 1000 && cyc < 30000) begin
            do_cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 99) < 2,
                     $urandom_range(0, 9) < 6, ir);
            cyc++;
        end
        check("t6_words_delivered", 64'((m_delivered - start) >= 1000), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
